apb_master: RTL



---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master.sv | 133 +++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB requester.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

  localparam int APB_ADDR_W  = 8;
  localparam int APB_DATA_W  = 8;
  localparam int APB_TIMEOUT = 16;

endpackage

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one SETUP/ACCESS bus
// transfer, holds address/data/direction across it, and returns a one-cycle
// response pulse. A wait-state counter aborts transfers to a silent slave.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              sel,
  output logic              enable,
  output logic              w_en,
  output logic [ADDR_W-1:0] add,
  output logic [DATA_W-1:0] wdata,
  input  logic              ready,
  input  logic [DATA_W-1:0] rdata
);

  // A zero TIMEOUT disables the abort, but the counter still needs one bit.
  localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  apb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, done_ok, done_to;

  logic              sel_q, enable_q, w_en_q;
  logic [ADDR_W-1:0] add_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_valid_q, rsp_timeout_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  // Next-state, wait counter and completion decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    done_ok = 1'b0;
    done_to = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        // A slave answering in the last allowed cycle still succeeds.
        if (ready) begin
          done_ok = 1'b1;
          state_d = IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          done_to = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered bus outputs; command fields are held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= 1'b0;
      enable_q <= 1'b0;
      w_en_q   <= 1'b0;
      add_q    <= '0;
      wdata_q  <= '0;
    end else begin
      sel_q    <= (state_d != IDLE);
      enable_q <= (state_d == ACCESS);
      if (accept) begin
        w_en_q  <= req_write;
        add_q   <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // One-cycle response pulse; read data is only passed on for good reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      rsp_valid_q   <= done_ok | done_to;
      rsp_timeout_q <= done_to;
      rsp_rdata_q   <= (done_ok && !w_en_q) ? rdata : '0;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign sel         = sel_q;
  assign enable      = enable_q;
  assign w_en        = w_en_q;
  assign add         = add_q;
  assign wdata       = wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule
